bias_trim_sar_cal: RTL and testbench

- Digital calibration controller for the on-chip analog bias generator.
- Drives the generator's binary trim code and reads back its comparator output (bias-vs-reference).
- Runs a successive-approximation (SAR) search to find the trim code where the bias crosses the reference.
- Holds the result on the trim bus until the next calibration or a manual override.

---
 rtl/bias_trim_sar_cal.sv | 145 ++++++++++++++
 tb/tb_bias_trim_sar_cal.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bias_trim_sar_cal.sv
// SAR trim calibration controller for the analog bias generator.
// Optional macro BIAS_CAL_AVG_EN: three-sample majority vote per bit decision.
module bias_trim_sar_cal #(
   parameter int TRIM_W     = 6,
   parameter int SETTLE_CYC = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              start,
   input  logic              cmp_in,
   input  logic              manual_en,
   input  logic [TRIM_W-1:0] manual_code,
   output logic [TRIM_W-1:0] trim_out,
   output logic              busy,
   output logic              done,
   output logic              cal_ok
);

   localparam int CNT_W = $clog2(SETTLE_CYC);
   localparam int IDX_W = $clog2(TRIM_W);
   localparam logic [TRIM_W-1:0] MID      = {1'b1, {(TRIM_W-1){1'b0}}};
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(TRIM_W - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t            state, state_nxt;
   logic              cmp_meta, cmp_s;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic [TRIM_W-1:0] result, saved, sar_next;
   logic              sample_last, decide, abort;

`ifdef BIAS_CAL_AVG_EN
   logic [1:0] scnt, votes;
   assign sample_last = (scnt == 2'd2);
   assign decide      = ((votes + {1'b0, cmp_s}) >= 2'd2);
`else
   assign sample_last = 1'b1;
   assign decide      = cmp_s;
`endif

   assign abort    = !ena && (state == SETTLE || state == SAMPLE);
   assign trim_out = (state == IDLE && manual_en) ? manual_code : result;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_meta <= 1'b0;
         cmp_s    <= 1'b0;
      end else begin
         cmp_meta <= cmp_in;
         cmp_s    <= cmp_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:   if (ena && start && !manual_en) state_nxt = SETTLE;
         SETTLE: begin
            busy = 1'b1;
            if (!ena)             state_nxt = IDLE;
            else if (cnt == '0)   state_nxt = SAMPLE;
         end
         SAMPLE: begin
            busy = 1'b1;
            if (!ena)             state_nxt = IDLE;
            else if (sample_last) state_nxt = (idx == '0) ? DONE : SETTLE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Clear the bit under test if the bias was high, then raise the next one.
   always_comb begin
      sar_next = result;
      if (decide)     sar_next[idx] = 1'b0;
      if (idx != '0)  sar_next[idx - IDX_W'(1)] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= MID;
         saved  <= MID;
         cnt    <= '0;
         idx    <= IDX_TOP;
         cal_ok <= 1'b0;
`ifdef BIAS_CAL_AVG_EN
         scnt   <= 2'd0;
         votes  <= 2'd0;
`endif
      end else if (abort) begin
         result <= saved;
         cal_ok <= 1'b0;
`ifdef BIAS_CAL_AVG_EN
         scnt   <= 2'd0;
         votes  <= 2'd0;
`endif
      end else begin
         case (state)
            IDLE: if (state_nxt == SETTLE) begin
               saved  <= result;
               result <= MID;
               idx    <= IDX_TOP;
               cnt    <= CNT_LOAD;
            end
            SETTLE: if (cnt != '0) cnt <= cnt - CNT_W'(1);
            SAMPLE: begin
`ifdef BIAS_CAL_AVG_EN
               if (!sample_last) begin
                  scnt  <= scnt + 2'd1;
                  votes <= votes + {1'b0, cmp_s};
               end else begin
                  scnt  <= 2'd0;
                  votes <= 2'd0;
               end
`endif
               if (sample_last) begin
                  result <= sar_next;
                  if (idx != '0) begin
                     idx <= idx - IDX_W'(1);
                     cnt <= CNT_LOAD;
                  end else begin
                     cal_ok <= (sar_next != '0) && (sar_next != '1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bias_trim_sar_cal.sv
// Self-checking bench for bias_trim_sar_cal with a threshold comparator model.
module tb_bias_trim_sar_cal;

   localparam int TRIM_W     = 6;
   localparam int SETTLE_CYC = 16;
`ifdef BIAS_CAL_AVG_EN
   localparam int SAMP = 3;
`else
   localparam int SAMP = 1;
`endif
   localparam int EXP_DONE = TRIM_W * (SETTLE_CYC + SAMP) + 1;
   localparam int EXP_BUSY = EXP_DONE - 1;
   localparam int LIMIT    = EXP_DONE + 5;
   localparam int MIDV     = 1 << (TRIM_W - 1);
   localparam int MAXV     = (1 << TRIM_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n, ena, start, cmp_in, manual_en;
   logic [TRIM_W-1:0] manual_code, trim_out;
   logic              busy, done, cal_ok;
   int                thr;
   int                checks = 0;
   int                errors = 0;
   int                held   = MIDV;

   bias_trim_sar_cal #(.TRIM_W(TRIM_W), .SETTLE_CYC(SETTLE_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cmp_in(cmp_in),
      .manual_en(manual_en), .manual_code(manual_code),
      .trim_out(trim_out), .busy(busy), .done(done), .cal_ok(cal_ok)
   );

   always #5 clk = ~clk;

   // Bias generator: comparator is high whenever the trim code exceeds thr.
   assign cmp_in = (int'(trim_out) > thr);

   // The settled answer is the largest code whose comparator reads low, else 0.
   function automatic int ref_result(input int t);
      int best = 0;
      for (int c = 0; c <= MAXV; c++) if (!(c > t)) best = c;
      return best;
   endfunction

   task automatic start_cal();
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
   endtask

   task automatic run_cal(input int restart_at, input int abort_at, input int manual_at,
                          output int done_at, output int busy_n, output int trim_d,
                          output logic ok_d, output logic busy_abort);
      int n;
      start_cal();
      n = 1; done_at = 0; busy_n = 0; trim_d = -1; ok_d = 1'bx; busy_abort = 1'bx;
      while (n <= LIMIT && done_at == 0) begin
         if (busy === 1'b1) busy_n++;
         if (done === 1'b1) begin
            done_at = n; trim_d = int'(trim_out); ok_d = cal_ok;
         end
         if (n == abort_at + 1) begin busy_abort = busy; ena = 1'b1; end
         start = (n == restart_at);
         if (n == abort_at) ena = 1'b0;
         if (n == manual_at) begin manual_en = 1'b1; manual_code = 6'd5; end
         if (done_at == 0) begin @(posedge clk); #1; n++; end
      end
      start = 1'b0;
   endtask

   task automatic check_cal(input string name, input int t);
      int da, bn, td, exp;
      logic ok, ba;
      thr = t;
      exp = ref_result(t);
      run_cal(0, 0, 0, da, bn, td, ok, ba);
      checks++; if (da !== EXP_DONE) begin errors++; $display("[TB] FAIL %s done_cycle got %0d expected %0d", name, da, EXP_DONE); end
      checks++; if (bn !== EXP_BUSY) begin errors++; $display("[TB] FAIL %s busy_cycles got %0d expected %0d", name, bn, EXP_BUSY); end
      checks++; if (td !== exp) begin errors++; $display("[TB] FAIL %s trim got %0d expected %0d", name, td, exp); end
      checks++; if (ok !== (exp != 0 && exp != MAXV)) begin errors++; $display("[TB] FAIL %s cal_ok got %0b expected %0b", name, ok, (exp != 0 && exp != MAXV)); end
      held = exp;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b0; start = 1'b0; manual_en = 1'b0; manual_code = '0; thr = 37;
      repeat (3) @(posedge clk); #1;
      checks++; if (trim_out !== 6'(MIDV)) begin errors++; $display("[TB] FAIL reset_trim got %0d expected %0d", trim_out, MIDV); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b expected 0", done); end
      checks++; if (cal_ok !== 1'b0) begin errors++; $display("[TB] FAIL reset_cal_ok got %0b expected 0", cal_ok); end
      rst_n = 1'b1; ena = 1'b1;
      held = MIDV;
      @(posedge clk); #1;
   endtask

   task automatic test_nominal();
      check_cal("nominal", 37);
   endtask

   task automatic test_saturation();
      check_cal("sat_high", -1);
      check_cal("sat_low", MAXV);
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) check_cal("random", int'($urandom_range(0, MAXV + 1)) - 1);
   endtask

   task automatic test_abort();
      int da, bn, td;
      logic ok, ba;
      check_cal("abort_prior", 37);
      thr = 10;
      run_cal(0, 50, 0, da, bn, td, ok, ba);
      checks++; if (ba !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %0b expected 0", ba); end
      checks++; if (da !== 0) begin errors++; $display("[TB] FAIL abort_done got cycle %0d expected none", da); end
      checks++; if (trim_out !== 6'd37) begin errors++; $display("[TB] FAIL abort_trim got %0d expected 37", trim_out); end
      checks++; if (cal_ok !== 1'b0) begin errors++; $display("[TB] FAIL abort_cal_ok got %0b expected 0", cal_ok); end
      held = 37;
   endtask

   task automatic test_manual();
      logic [TRIM_W-1:0] code;
      manual_en = 1'b1; manual_code = 6'd9; #1;
      checks++; if (trim_out !== 6'd9) begin errors++; $display("[TB] FAIL manual_trim got %0d expected 9", trim_out); end
      start_cal();
      repeat (3) @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL manual_start_ignored busy got %0b expected 0", busy); end
      for (int i = 0; i < 3; i++) begin
         code = TRIM_W'($urandom);
         manual_code = code; #1;
         checks++; if (trim_out !== code) begin errors++; $display("[TB] FAIL manual_random got %0d expected %0d", trim_out, code); end
      end
      manual_en = 1'b0; #1;
      checks++; if (trim_out !== TRIM_W'(held)) begin errors++; $display("[TB] FAIL manual_release got %0d expected %0d", trim_out, held); end
      ena = 1'b0;
      start_cal();
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ena_low_start_ignored busy got %0b expected 0", busy); end
      ena = 1'b1;
   endtask

   task automatic test_back_to_back();
      int da, bn, td, exp;
      logic ok, ba;
      thr = int'($urandom_range(1, MAXV - 2));
      exp = ref_result(thr);
      run_cal(20, 0, 30, da, bn, td, ok, ba);
      checks++; if (da !== EXP_DONE) begin errors++; $display("[TB] FAIL restart_done_cycle got %0d expected %0d", da, EXP_DONE); end
      checks++; if (td !== exp) begin errors++; $display("[TB] FAIL restart_trim got %0d expected %0d", td, exp); end
      @(posedge clk); #1;
      checks++; if (trim_out !== 6'd5) begin errors++; $display("[TB] FAIL late_manual_trim got %0d expected 5", trim_out); end
      manual_en = 1'b0; #1;
      checks++; if (trim_out !== TRIM_W'(exp)) begin errors++; $display("[TB] FAIL late_manual_release got %0d expected %0d", trim_out, exp); end
      held = exp;
   endtask

   task automatic test_reset_mid();
      thr = 20;
      start_cal();
      repeat (40) @(posedge clk);
      #2 rst_n = 1'b0; #1;
      checks++; if (trim_out !== 6'(MIDV)) begin errors++; $display("[TB] FAIL midreset_trim got %0d expected %0d", trim_out, MIDV); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %0b expected 0", busy); end
      checks++; if (cal_ok !== 1'b0) begin errors++; $display("[TB] FAIL midreset_cal_ok got %0b expected 0", cal_ok); end
      @(posedge clk); #1; rst_n = 1'b1;
      held = MIDV;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_saturation();
      test_random();
      test_abort();
      test_manual();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
